// File: rtl/jtag_dr_engine_pkg.sv
// Shared constants and types for the JTAG DR shift engine: IR coding,
// control-bit positions in the synchroniser bundle, and the engine state type.
package jtag_dr_engine_pkg;

  localparam int JTAG_IR_LENGTH  = 4;
  localparam int JTAG_IR_CH_BASE = 1;

  localparam int CTL_TCK = 0;
  localparam int CTL_TDI = 1;
  localparam int CTL_CAP = 2;
  localparam int CTL_SHF = 3;
  localparam int CTL_UPD = 4;
  localparam int CTL_W   = 5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } dr_state_e;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/jtag_sync.sv
// Parametrised-width 2-flop synchroniser with a third flop per bit for
// rising-edge detection; o_q and o_rise carry the same latency.
module jtag_sync #(
  parameter int W = 1
) (
  input  logic         clk_50_,
  input  logic         reset_n_,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q,
  output logic [W-1:0] o_rise
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;
  logic [W-1:0] r_s3;

  always_ff @(posedge clk_50_) begin
    if (!reset_n_) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_q    = r_s2;
  assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/jtag_dr_engine.sv
// DR shift engine: NUM_CH IR-selected capture/update registers plus bypass,
// driven by synchronised virtual-JTAG TAP signals in the clk_50_ domain.
module jtag_dr_engine
  import jtag_dr_engine_pkg::*;
#(
  parameter int IR_LENGTH = JTAG_IR_LENGTH,
  parameter int DR_WIDTH  = 32,
  parameter int NUM_CH    = 4,
  parameter int IR_BASE   = JTAG_IR_CH_BASE,
  localparam int CH_W     = ch_width(NUM_CH),
  localparam int LEN_W    = $clog2(DR_WIDTH + 1)
) (
  input  logic                       clk_50_,
  input  logic                       reset_n_,
  input  logic                       tck,
  input  logic                       tdi,
  input  logic                       capture_dr,
  input  logic                       shift_dr,
  input  logic                       update_dr,
  input  logic [IR_LENGTH-1:0]       ir,
  output logic                       tdo,
  input  logic [NUM_CH*DR_WIDTH-1:0] cap_data,
  output logic                       upd_valid,
  output logic [CH_W-1:0]            upd_ch,
  output logic [DR_WIDTH-1:0]        upd_data,
  output logic [LEN_W-1:0]           upd_len,
  output logic                       upd_ovf
);

  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] c);
    return (c == LEN_W'(DR_WIDTH)) ? c : c + LEN_W'(1);
  endfunction

  logic [CTL_W-1:0]     w_ctl_q;
  logic [CTL_W-1:0]     w_ctl_rise;
  logic [IR_LENGTH-1:0] w_ir;
  logic [IR_LENGTH-1:0] w_ir_rise;
  logic                 w_unused;

  jtag_sync #(.W(CTL_W)) u_sync_ctl (
    .clk_50_  (clk_50_),
    .reset_n_ (reset_n_),
    .i_d      ({update_dr, shift_dr, capture_dr, tdi, tck}),
    .o_q      (w_ctl_q),
    .o_rise   (w_ctl_rise)
  );

  jtag_sync #(.W(IR_LENGTH)) u_sync_ir (
    .clk_50_  (clk_50_),
    .reset_n_ (reset_n_),
    .i_d      (ir),
    .o_q      (w_ir),
    .o_rise   (w_ir_rise)
  );

  assign w_unused = &{1'b0, w_ctl_rise[CTL_SHF:CTL_TDI], w_ir_rise};

  dr_state_e             r_state;
  dr_state_e             w_state_nxt;
  logic [DR_WIDTH-1:0]   r_sr;
  logic                  r_byp_bit;
  logic                  r_bypass;
  logic [CH_W-1:0]       r_ch;
  logic [LEN_W-1:0]      r_cnt;
  logic                  r_ovf;

  logic                  w_do_cap;
  logic                  w_do_shift;
  logic                  w_do_upd;
  logic [31:0]           w_ir_ext;
  logic                  w_ir_hit;
  logic [CH_W-1:0]       w_ch;
  logic [DR_WIDTH-1:0]   w_cap_sel;

  // Flags are taken from the same sync stage that produces the tck edge.
  assign w_do_cap   = w_ctl_rise[CTL_TCK] & w_ctl_q[CTL_CAP];
  assign w_do_shift = w_ctl_rise[CTL_TCK] & w_ctl_q[CTL_SHF] & ~w_ctl_q[CTL_CAP]
                    & (r_state == ST_SHIFT);
  assign w_do_upd   = w_ctl_rise[CTL_UPD] & ~w_do_cap & (r_state == ST_SHIFT);

  assign w_ir_ext = 32'(w_ir);
  assign w_ir_hit = (w_ir_ext >= 32'(IR_BASE)) && (w_ir_ext < 32'(IR_BASE + NUM_CH));
  assign w_ch     = CH_W'(w_ir_ext - 32'(IR_BASE));

  always_comb begin
    w_cap_sel = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_ch == CH_W'(k)) w_cap_sel = cap_data[k*DR_WIDTH +: DR_WIDTH];
    end
  end

  always_ff @(posedge clk_50_) begin
    if (!reset_n_) r_state <= ST_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_do_cap)      w_state_nxt = ST_SHIFT;
    else if (w_do_upd) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk_50_) begin
    if (!reset_n_) begin
      r_sr      <= '0;
      r_byp_bit <= 1'b0;
      r_bypass  <= 1'b0;
      r_ch      <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      tdo       <= 1'b0;
      upd_valid <= 1'b0;
      upd_ch    <= '0;
      upd_data  <= '0;
      upd_len   <= '0;
      upd_ovf   <= 1'b0;
    end else begin
      upd_valid <= 1'b0;
      tdo       <= r_bypass ? r_byp_bit : r_sr[0];
      if (w_do_cap) begin
        r_ch      <= w_ch;
        r_bypass  <= ~w_ir_hit;
        r_sr      <= w_ir_hit ? w_cap_sel : '0;
        r_byp_bit <= 1'b0;
        r_cnt     <= '0;
        r_ovf     <= 1'b0;
      end else if (w_do_shift) begin
        if (r_bypass) r_byp_bit <= w_ctl_q[CTL_TDI];
        else          r_sr      <= {w_ctl_q[CTL_TDI], r_sr[DR_WIDTH-1:1]};
        r_cnt <= sat_inc(r_cnt);
        if (r_cnt == LEN_W'(DR_WIDTH)) r_ovf <= 1'b1;
      end
      // Bypass scans complete silently; only real channels report.
      if (w_do_upd && !r_bypass) begin
        upd_valid <= 1'b1;
        upd_ch    <= r_ch;
        upd_data  <= r_sr;
        upd_len   <= r_cnt;
        upd_ovf   <= r_ovf;
      end
    end
  end

endmodule
